quad_inverse_search: RTL and testbench
======================================

Name: quad_inverse_search

Overview:
- Sequential inverse of the quadratic evaluator y = A*x^2 + B*x + C.
- Accepts a signed target y over a valid/ready handshake and sweeps every signed W_X-bit candidate x, one per clock.
- Returns the x whose exact quadratic value is closest to y, plus the absolute error and an exact-hit flag.
- Replaces the combinational brute-force inverse table in datapaths where area matters more than latency.

Parameters:
W_X, 4, candidate/result width (signed x range -2^(W_X-1) .. 2^(W_X-1)-1)
W_Y, 8, target input width (signed)
W_E, 16, error output width (unsigned, saturating)
A, 1, signed quadratic coefficient
B, 10, signed linear coefficient
C, -10, signed constant term

Ports:
clk  in  1  single clock, all state on rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  target y_in valid
in_ready  out  1  block idle, can accept target
y_in  in  W_Y  signed target value
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
x_out  out  W_X  signed best candidate
err_out  out  W_E  |y - q(x_out)|, saturated to 2^W_E-1
exact  out  1  err == 0

Behaviour:
- Reset (rst high at edge): state=IDLE, out_valid=0, x_out=0, err_out=0, exact=0, internal index/min registers cleared. in_ready=0 while rst is high.
- in_ready = (state==IDLE) && !rst; combinational from state.
- States:
  - IDLE: on in_valid && in_ready, latch y_in, set idx to -2^(W_X-1), set min_err to 0xFFFF_FFFF, go to SEARCH.
  - SEARCH: each cycle evaluate candidate idx. If err < min_err (strict), update best_x=idx and min_err=err. Increment idx. After evaluating idx = 2^(W_X-1)-1, go to DONE and register out_valid=1, x_out, err_out, exact.
  - DONE: hold all outputs stable. On out_valid && out_ready, go to IDLE and drop out_valid. in_ready=1 the following cycle.
- Latency: out_valid rises exactly 2^W_X cycles after the accepting edge (16 at defaults). Throughput is one result per 2^W_X+2 cycles minimum. No overlap between requests.
- Arithmetic: q(x) is computed in 32-bit signed from sign-extended x and sign-extended A, B, C. It is never truncated to W_Y. err = |sext(y) - q| in 32 bits, and err_out = min(err, 2^W_E-1).
- Tie-break: the strict-less compare keeps the most negative x among equal minima.
- Search order is idx ascending from the most negative value. idx wraps only at exit and is not used afterwards.
- in_valid while busy (SEARCH/DONE): ignored, not queued. y_in is sampled only at the accepting edge, so later changes to y_in have no effect.
- out_ready high while not in DONE: no effect.
- rst mid-SEARCH or mid-DONE: abort immediately, apply reset values next cycle, pending result discarded.
- out_ready held low: DONE persists indefinitely, outputs unchanged.

Test Plan:
- Exact hit: y_in=14 (defaults) -> 16 cycles after accept, out_valid=1, x_out=2, err_out=0, exact=1.
- Tie-break: y_in=-30 (q(-7)=q(-3)=-31) -> x_out=-7, err_out=1, exact=0. Also y_in=-34 -> x_out=-6, err_out=0.
- Nearest non-exact: y_in=20 -> x_out=2, err_out=6. y_in=127 -> x_out=7, err_out=18. y_in=-128 -> x_out=-5, err_out=93.
- Backpressure and ignored input: hold out_ready=0 for 5 cycles in DONE -> outputs stable and in_ready=0 throughout. in_valid pulses during SEARCH are not accepted. Raise out_ready -> out_valid=0 next cycle, then in_ready=1.
- Reset mid-operation: assert rst on SEARCH cycle 7 -> next cycle out_valid=0, x_out=0, err_out=0. After rst falls, in_ready=1, and a new y_in=1 yields x_out=1, err_out=0.
- Back-to-back: keep in_valid and out_ready high with y_in=46 then y_in=65 -> results x_out=4 then x_out=5, with result spacing of 2^W_X+2 cycles.

Source files
------------

// File: rtl/quad_inverse_search.sv
// Sequential inverse of y = A*x^2 + B*x + C. Each accepted target is compared against
// every signed W_X-bit candidate, one per clock. The block returns the candidate with the least absolute error.
module quad_inverse_search #(
    parameter int W_X = 4,
    parameter int W_Y = 8,
    parameter int W_E = 16,
    parameter int A   = 1,
    parameter int B   = 10,
    parameter int C   = -10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic signed [W_Y-1:0] y_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic signed [W_X-1:0] x_out,
    output logic        [W_E-1:0] err_out,
    output logic                  exact
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEARCH,
        S_DONE
    } state_t;

    localparam logic signed [W_X-1:0] X_MIN   = {1'b1, {(W_X-1){1'b0}}};
    localparam logic signed [W_X-1:0] X_MAX   = ~X_MIN;
    localparam logic        [W_E-1:0] ERR_SAT = '1;

    state_t                r_state;
    state_t                w_next_state;
    logic signed [W_Y-1:0] r_y;
    logic signed [W_X-1:0] r_idx;
    logic signed [W_X-1:0] r_best_x;
    logic        [31:0]    r_min_err;
    logic                  r_out_valid;
    logic signed [W_X-1:0] r_x_out;
    logic        [W_E-1:0] r_err_out;
    logic                  r_exact;

    logic signed [31:0]    w_x_ext;
    logic signed [31:0]    w_y_ext;
    logic signed [31:0]    w_q;
    logic signed [31:0]    w_diff;
    logic        [31:0]    w_err;
    logic                  w_take;
    logic                  w_last;
    logic signed [W_X-1:0] w_best_x;
    logic        [31:0]    w_best_err;
    logic        [W_E-1:0] w_best_sat;

    // Full 32-bit evaluation of the current candidate; q is never narrowed to W_Y.
    assign w_x_ext = {{(32-W_X){r_idx[W_X-1]}}, r_idx};
    assign w_y_ext = {{(32-W_Y){r_y[W_Y-1]}}, r_y};
    assign w_q     = A * w_x_ext * w_x_ext + B * w_x_ext + C;
    assign w_diff  = w_y_ext - w_q;
    assign w_err   = w_diff[31] ? -w_diff : w_diff;

    // Strict compare keeps the earliest, i.e. most negative, x among equal minima.
    assign w_take     = (w_err < r_min_err);
    assign w_last     = (r_idx == X_MAX);
    assign w_best_x   = w_take ? r_idx : r_best_x;
    assign w_best_err = w_take ? w_err : r_min_err;
    assign w_best_sat = (w_best_err > {{(32-W_E){1'b0}}, ERR_SAT}) ? ERR_SAT : w_best_err[W_E-1:0];

    assign in_ready  = (r_state == S_IDLE) && !rst;
    assign out_valid = r_out_valid;
    assign x_out     = r_x_out;
    assign err_out   = r_err_out;
    assign exact     = r_exact;

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next_state;
    end

    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (in_valid) w_next_state = S_SEARCH;
            S_SEARCH: if (w_last)   w_next_state = S_DONE;
            S_DONE:   if (out_ready) w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_y         <= '0;
            r_idx       <= '0;
            r_best_x    <= '0;
            r_min_err   <= '0;
            r_out_valid <= 1'b0;
            r_x_out     <= '0;
            r_err_out   <= '0;
            r_exact     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_y       <= y_in;
                        r_idx     <= X_MIN;
                        r_best_x  <= X_MIN;
                        r_min_err <= '1;
                    end
                end
                S_SEARCH: begin
                    r_best_x  <= w_best_x;
                    r_min_err <= w_best_err;
                    r_idx     <= r_idx + 1'b1;
                    if (w_last) begin
                        r_out_valid <= 1'b1;
                        r_x_out     <= w_best_x;
                        r_err_out   <= w_best_sat;
                        r_exact     <= (w_best_err == 32'd0);
                    end
                end
                S_DONE: begin
                    if (out_ready) r_out_valid <= 1'b0;
                end
                default: r_out_valid <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_quad_inverse_search.sv
// Self-checking bench for quad_inverse_search: directed cases, handshake corner cases and
// random targets are all checked against an exhaustive nearest-value search model.
module tb_quad_inverse_search;

    localparam int W_X = 4;
    localparam int W_Y = 8;
    localparam int W_E = 16;
    localparam int A   = 1;
    localparam int B   = 10;
    localparam int C   = -10;
    localparam int LAT = 1 << W_X;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  in_valid;
    logic                  in_ready;
    logic signed [W_Y-1:0] y_in;
    logic                  out_valid;
    logic                  out_ready;
    logic signed [W_X-1:0] x_out;
    logic        [W_E-1:0] err_out;
    logic                  exact;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    quad_inverse_search #(
        .W_X(W_X), .W_Y(W_Y), .W_E(W_E), .A(A), .B(B), .C(C)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .y_in     (y_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .x_out    (x_out),
        .err_out  (err_out),
        .exact    (exact)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: scan all candidates in ascending order; first strict minimum wins.
    task automatic model(input int y, output int bx, output int be);
        int e;
        int q;
        be = -1;
        bx = 0;
        for (int x = -(1 << (W_X-1)); x < (1 << (W_X-1)); x++) begin
            q = A*x*x + B*x + C;
            e = (y > q) ? (y - q) : (q - y);
            if (be < 0 || e < be) begin
                be = e;
                bx = x;
            end
        end
        if (be > (1 << W_E) - 1) be = (1 << W_E) - 1;
    endtask

    task automatic run_txn(input int y, input bit glitch, input int hold);
        int cnt;
        int bx;
        int be;
        int lx;
        int le;
        model(y, bx, be);
        cnt = 0;
        while (!in_ready && cnt < 50) begin
            step();
            cnt++;
        end
        check("ready_wait", int'(in_ready), 1);
        in_valid = 1'b1;
        y_in     = y[W_Y-1:0];
        step();
        in_valid = 1'b0;
        y_in     = 8'($urandom);
        cnt = 0;
        while (!out_valid && cnt < 100) begin
            if (glitch && cnt < 10) begin
                in_valid = 1'b1;
                y_in     = 8'($urandom);
            end else begin
                in_valid = 1'b0;
            end
            step();
            cnt++;
        end
        in_valid = 1'b0;
        check("latency", cnt, LAT);
        check("x_out", int'(x_out), bx);
        check("err_out", int'(err_out), be);
        check("exact", int'(exact), (be == 0) ? 1 : 0);
        check("busy_ready", int'(in_ready), 0);
        lx = int'(x_out);
        le = int'(err_out);
        repeat (hold) begin
            step();
            check("hold_valid", int'(out_valid), 1);
            check("hold_x", int'(x_out), lx);
            check("hold_err", int'(err_out), le);
            check("hold_ready", int'(in_ready), 0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("drop_valid", int'(out_valid), 0);
        check("ready_after", int'(in_ready), 1);
    endtask

    initial begin
        int directed[6];
        int cnt;
        int t1;
        int t2;
        int bx;
        int be;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        y_in      = '0;
        repeat (2) step();
        check("rst_valid", int'(out_valid), 0);
        check("rst_x", int'(x_out), 0);
        check("rst_err", int'(err_out), 0);
        check("rst_exact", int'(exact), 0);
        check("rst_ready", int'(in_ready), 0);
        rst = 1'b0;
        #1;
        check("post_rst_ready", int'(in_ready), 1);

        // Exact hit, tie-breaks and nearest non-exact targets, including range extremes.
        directed = '{14, -30, -34, 20, 127, -128};
        foreach (directed[i]) run_txn(directed[i], 1'b0, 0);

        // Backpressure with busy-time in_valid pulses that must be ignored.
        run_txn(-7, 1'b1, 5);

        // Reset in the seventh search cycle discards the pending result.
        run_txn(127, 1'b0, 0);
        in_valid = 1'b1;
        y_in     = 8'sd50;
        step();
        in_valid = 1'b0;
        repeat (6) step();
        rst = 1'b1;
        #1;
        check("midrst_ready", int'(in_ready), 0);
        step();
        check("midrst_valid", int'(out_valid), 0);
        check("midrst_x", int'(x_out), 0);
        check("midrst_err", int'(err_out), 0);
        check("midrst_exact", int'(exact), 0);
        rst = 1'b0;
        #1;
        check("midrst_ready_after", int'(in_ready), 1);
        run_txn(1, 1'b0, 0);

        // Back-to-back with in_valid and out_ready held high.
        y_in      = 8'sd46;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        cnt = 0;
        while (!out_valid && cnt < 100) begin
            step();
            cnt++;
        end
        t1 = cyc;
        model(46, bx, be);
        check("b2b_x1", int'(x_out), bx);
        check("b2b_err1", int'(err_out), be);
        y_in = 8'sd65;
        step();
        cnt = 0;
        while (!out_valid && cnt < 100) begin
            step();
            cnt++;
        end
        t2 = cyc;
        in_valid = 1'b0;
        model(65, bx, be);
        check("b2b_x2", int'(x_out), bx);
        check("b2b_err2", int'(err_out), be);
        check("b2b_spacing", t2 - t1, LAT + 2);
        step();
        out_ready = 1'b0;
        check("b2b_drop", int'(out_valid), 0);

        // Random targets with random backpressure and busy-time noise.
        for (int i = 0; i < 25; i++) begin
            run_txn(int'($urandom_range(255)) - 128, 1'($urandom_range(1)), int'($urandom_range(3)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
